// File: rtl/xps_math_pkg.sv
// Shared constants for the xps_math reconfigurable-region engines.
package xps_math_pkg;
    localparam logic [1:0]  MODE_MAX      = 2'b00;
    localparam logic [1:0]  MODE_MIN      = 2'b01;
    localparam int          MODE_MIN_BIT  = 0;
    localparam int          MODE_SIGNED   = 1;
    localparam logic [15:0] DEF_SIGNATURE = 16'hf00d;
    localparam int          CNT_W         = 16;
    localparam logic [CNT_W-1:0] CNT_MAX  = 16'hFFFF;
endpackage

// File: rtl/maxmin_reduce.sv
// Combinational max/min compare tree over NUM_IN operands, ties keep the lower index.
module maxmin_reduce
    import xps_math_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
) (
    input  logic [NUM_IN*WIDTH-1:0] data,
    input  logic [1:0]              mode,
    output logic [WIDTH-1:0]        red
);
    localparam int LVLS = $clog2(NUM_IN);

    logic [WIDTH-1:0] node [NUM_IN];

    // Flipping the sign bit maps two's complement order onto unsigned order.
    function automatic logic take_b(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic [1:0] m);
        logic [WIDTH-1:0] ka;
        logic [WIDTH-1:0] kb;
        ka = a;
        kb = b;
        if (m[MODE_SIGNED]) begin
            ka[WIDTH-1] = ~a[WIDTH-1];
            kb[WIDTH-1] = ~b[WIDTH-1];
        end
        return m[MODE_MIN_BIT] ? (kb < ka) : (kb > ka);
    endfunction

    // Reduced in place: level l writes node[i] from node[2i], node[2i+1].
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            node[i] = data[i*WIDTH +: WIDTH];
        end
        for (int l = 0; l < LVLS; l++) begin
            for (int i = 0; i < (NUM_IN >> (l + 1)); i++) begin
                node[i] = take_b(node[2*i], node[2*i+1], mode) ? node[2*i+1] : node[2*i];
            end
        end
        red = node[0];
    end
endmodule

// File: rtl/maxmin_stream.sv
// Streaming max/min reducer with change statistic and state restore for module swap.
module maxmin_stream
    import xps_math_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter int          NUM_IN    = 4,
    parameter logic [15:0] SIGNATURE = DEF_SIGNATURE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [1:0]              mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        result,
    output logic [31:0]             statistic,
    input  logic                    cnt_clr,
    input  logic                    restore_en,
    input  logic [WIDTH-1:0]        restore_res,
    input  logic [CNT_W-1:0]        restore_cnt
);
    logic [WIDTH-1:0] red;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    maxmin_reduce #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) u_reduce (
        .data (in_data),
        .mode (mode),
        .red  (red)
    );

    assign in_ready  = !restore_en && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign statistic = {SIGNATURE, cnt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= '0;
            out_valid <= 1'b0;
        end else if (restore_en) begin
            result    <= restore_res;
            out_valid <= 1'b0;
        end else if (accept) begin
            result    <= red;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restore_en) begin
            cnt <= restore_cnt;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (accept && (red != result) && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule
